// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel memory-to-memory copy engine.
// Copies wordCount 32-bit words from srcAddress to dstAddress one word at a
// time (read address, read data, write), acting as the DMA bus master.
module dma_copy_engine #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   resetActiveLow,
  input  logic                   start,
  input  logic [31:0]            srcAddress,
  input  logic [31:0]            dstAddress,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] wordsDone,
  output logic [31:0]            dmaAxiReadAddress,
  output logic                   dmaAxiReadValid,
  input  logic                   dmaAxiReadReady,
  input  logic [31:0]            dmaAxiReadData,
  input  logic                   dmaAxiReadValidData,
  output logic                   dmaAxiReadReadyData,
  output logic [31:0]            dmaAxiWriteAddress,
  output logic                   dmaAxiWriteValid,
  input  logic                   dmaAxiWriteReady,
  output logic [31:0]            dmaAxiWriteData,
  output logic                   dmaAxiWriteValidData,
  input  logic                   dmaAxiWriteReadyData
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CountZero = '0;
  localparam logic [COUNT_WIDTH-1:0] CountOne  = COUNT_WIDTH'(1);
  localparam logic [31:0]            WordStep  = 32'd4;

  state_e                 state_q, state_d;
  logic [31:0]            rdPtr_q, rdPtr_d;
  logic [31:0]            wrPtr_q, wrPtr_d;
  logic [31:0]            dataReg_q, dataReg_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] wordsDone_q, wordsDone_d;
  logic                   addrSent_q, addrSent_d;
  logic                   dataSent_q, dataSent_d;
  logic                   addrDoneNow, dataDoneNow;

  // State and datapath registers; reset clears everything so all outputs read zero.
  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q     <= IDLE;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      dataReg_q   <= '0;
      remaining_q <= '0;
      wordsDone_q <= '0;
      addrSent_q  <= 1'b0;
      dataSent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      dataReg_q   <= dataReg_d;
      remaining_q <= remaining_d;
      wordsDone_q <= wordsDone_d;
      addrSent_q  <= addrSent_d;
      dataSent_q  <= dataSent_d;
    end
  end

  // Next-state and datapath updates; a write word retires only once both channels have handshaken.
  always_comb begin
    state_d     = state_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    dataReg_d   = dataReg_q;
    remaining_d = remaining_q;
    wordsDone_d = wordsDone_q;
    addrSent_d  = addrSent_q;
    dataSent_d  = dataSent_q;
    addrDoneNow = addrSent_q | dmaAxiWriteReady;
    dataDoneNow = dataSent_q | dmaAxiWriteReadyData;

    case (state_q)
      IDLE: begin
        if (start) begin
          wordsDone_d = CountZero;
          if (wordCount != CountZero) begin
            rdPtr_d     = srcAddress;
            wrPtr_d     = dstAddress;
            remaining_d = wordCount;
            addrSent_d  = 1'b0;
            dataSent_d  = 1'b0;
            state_d     = RD_ADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ADDR: begin
        if (dmaAxiReadReady) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (dmaAxiReadValidData) begin
          dataReg_d = dmaAxiReadData;
          rdPtr_d   = rdPtr_q + WordStep;
          state_d   = WR;
        end
      end
      WR: begin
        if (addrDoneNow && dataDoneNow) begin
          wrPtr_d     = wrPtr_q + WordStep;
          remaining_d = remaining_q - CountOne;
          wordsDone_d = wordsDone_q + CountOne;
          addrSent_d  = 1'b0;
          dataSent_d  = 1'b0;
          state_d     = (remaining_q == CountOne) ? DONE : RD_ADDR;
        end else begin
          addrSent_d = addrDoneNow;
          dataSent_d = dataDoneNow;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy                 = (state_q == RD_ADDR) || (state_q == RD_DATA) || (state_q == WR);
  assign done                 = (state_q == DONE);
  assign wordsDone            = wordsDone_q;
  assign dmaAxiReadAddress    = rdPtr_q;
  assign dmaAxiReadValid      = (state_q == RD_ADDR);
  assign dmaAxiReadReadyData  = (state_q == RD_DATA);
  assign dmaAxiWriteAddress   = wrPtr_q;
  assign dmaAxiWriteData      = dataReg_q;
  assign dmaAxiWriteValid     = (state_q == WR) && !addrSent_q;
  assign dmaAxiWriteValidData = (state_q == WR) && !dataSent_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed, table-driven bench for dma_copy_engine with a
// small bus slave model (zero-wait reads, configurable write-ready delays).
module tb_dma_copy_engine;

  logic        clock;
  logic        resetActiveLow;
  logic        start;
  logic [31:0] srcAddress;
  logic [31:0] dstAddress;
  logic [15:0] wordCount;
  logic        busy;
  logic        done;
  logic [15:0] wordsDone;
  logic [31:0] dmaAxiReadAddress;
  logic        dmaAxiReadValid;
  logic        dmaAxiReadReady;
  logic [31:0] dmaAxiReadData;
  logic        dmaAxiReadValidData;
  logic        dmaAxiReadReadyData;
  logic [31:0] dmaAxiWriteAddress;
  logic        dmaAxiWriteValid;
  logic        dmaAxiWriteReady;
  logic [31:0] dmaAxiWriteData;
  logic        dmaAxiWriteValidData;
  logic        dmaAxiWriteReadyData;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    int          awDelay;
    int          wDelay;
    bit          midStart;
    int          expDone;
    logic [15:0] expWords;
  } jobVec_t;

  int checks = 0;
  int errors = 0;

  int awDelay = 0;
  int wDelay  = 0;
  int awCnt   = 0;
  int wCnt    = 0;
  int validCycles = 0;

  logic [31:0] rdLog[$];
  logic [31:0] awLog[$];
  logic [31:0] wLog[$];

  dma_copy_engine #(.COUNT_WIDTH(16)) dut (
    .clock                (clock),
    .resetActiveLow       (resetActiveLow),
    .start                (start),
    .srcAddress           (srcAddress),
    .dstAddress           (dstAddress),
    .wordCount            (wordCount),
    .busy                 (busy),
    .done                 (done),
    .wordsDone            (wordsDone),
    .dmaAxiReadAddress    (dmaAxiReadAddress),
    .dmaAxiReadValid      (dmaAxiReadValid),
    .dmaAxiReadReady      (dmaAxiReadReady),
    .dmaAxiReadData       (dmaAxiReadData),
    .dmaAxiReadValidData  (dmaAxiReadValidData),
    .dmaAxiReadReadyData  (dmaAxiReadReadyData),
    .dmaAxiWriteAddress   (dmaAxiWriteAddress),
    .dmaAxiWriteValid     (dmaAxiWriteValid),
    .dmaAxiWriteReady     (dmaAxiWriteReady),
    .dmaAxiWriteData      (dmaAxiWriteData),
    .dmaAxiWriteValidData (dmaAxiWriteValidData),
    .dmaAxiWriteReadyData (dmaAxiWriteReadyData)
  );

  // Free-running 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM contents the slave returns: 0xA0 plus the word index within a 1 KiB window
  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'h000000A0 + {24'h0, a[9:2]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Bus slave: handshakes are sampled mid-cycle (inputs only change just after posedge),
  // responses are driven just after the following posedge.
  initial begin : slave
    logic        rdAddrHs, rdDataHs, awHs, wHs;
    logic        prevAwPend, prevWPend;
    logic [31:0] prevAwAddr, prevWData, pendRdAddr;
    rdAddrHs = 0; rdDataHs = 0; awHs = 0; wHs = 0;
    prevAwPend = 0; prevWPend = 0;
    prevAwAddr = 0; prevWData = 0; pendRdAddr = 0;
    forever begin
      @(negedge clock);
      if (!resetActiveLow) begin
        prevAwPend = 0;
        prevWPend  = 0;
        rdAddrHs = 0; rdDataHs = 0; awHs = 0; wHs = 0;
      end else begin
        rdAddrHs = dmaAxiReadValid && dmaAxiReadReady;
        rdDataHs = dmaAxiReadValidData && dmaAxiReadReadyData;
        awHs     = dmaAxiWriteValid && dmaAxiWriteReady;
        wHs      = dmaAxiWriteValidData && dmaAxiWriteReadyData;
        if (dmaAxiReadValid || dmaAxiReadReadyData || dmaAxiWriteValid || dmaAxiWriteValidData)
          validCycles++;
        if (prevAwPend) begin
          checkOutput("awValidHeld", {31'h0, dmaAxiWriteValid}, 32'h1);
          checkOutput("awAddrStable", dmaAxiWriteAddress, prevAwAddr);
        end
        if (prevWPend) begin
          checkOutput("wValidHeld", {31'h0, dmaAxiWriteValidData}, 32'h1);
          checkOutput("wDataStable", dmaAxiWriteData, prevWData);
        end
        if (rdAddrHs) begin
          rdLog.push_back(dmaAxiReadAddress);
          pendRdAddr = dmaAxiReadAddress;
        end
        if (awHs) awLog.push_back(dmaAxiWriteAddress);
        if (wHs)  wLog.push_back(dmaAxiWriteData);
        prevAwPend = dmaAxiWriteValid && !awHs;
        prevAwAddr = dmaAxiWriteAddress;
        prevWPend  = dmaAxiWriteValidData && !wHs;
        prevWData  = dmaAxiWriteData;
      end
      @(posedge clock);
      #1;
      if (!resetActiveLow) begin
        dmaAxiReadReady      = 1'b0;
        dmaAxiReadValidData  = 1'b0;
        dmaAxiReadData       = 32'h0;
        dmaAxiWriteReady     = 1'b0;
        dmaAxiWriteReadyData = 1'b0;
        awCnt = 0;
        wCnt  = 0;
      end else begin
        dmaAxiReadReady = 1'b1;
        if (rdAddrHs) begin
          dmaAxiReadValidData = 1'b1;
          dmaAxiReadData      = memData(pendRdAddr);
        end else if (rdDataHs) begin
          dmaAxiReadValidData = 1'b0;
        end
        if (dmaAxiWriteValid) begin
          dmaAxiWriteReady = (awCnt >= awDelay);
          awCnt++;
        end else begin
          dmaAxiWriteReady = 1'b0;
          awCnt = 0;
        end
        if (dmaAxiWriteValidData) begin
          dmaAxiWriteReadyData = (wCnt >= wDelay);
          wCnt++;
        end else begin
          dmaAxiWriteReadyData = 1'b0;
          wCnt = 0;
        end
      end
    end
  end

  // Runs one job: start, optional mid-job start pulse, completion timing and bus log checks
  task automatic applyStimulus(input jobVec_t v, input int idx);
    int doneAt;
    logic busyAtDone;
    rdLog.delete();
    awLog.delete();
    wLog.delete();
    awDelay = v.awDelay;
    wDelay  = v.wDelay;
    @(negedge clock);
    validCycles = 0;
    srcAddress = v.src;
    dstAddress = v.dst;
    wordCount  = v.count;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput($sformatf("job%0d_busyAfterStart", idx), {31'h0, busy}, (v.count != 0) ? 32'h1 : 32'h0);
    doneAt = -1;
    busyAtDone = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        doneAt = k;
        busyAtDone = busy;
        break;
      end
      if (v.midStart && k == 4) begin
        srcAddress = 32'h60000000;
        dstAddress = 32'h60000800;
        wordCount  = 16'd7;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    checkOutput($sformatf("job%0d_doneCycle", idx), doneAt, v.expDone);
    checkOutput($sformatf("job%0d_busyAtDone", idx), {31'h0, busyAtDone}, 32'h0);
    checkOutput($sformatf("job%0d_wordsDone", idx), {16'h0, wordsDone}, {16'h0, v.expWords});
    @(posedge clock);
    #1;
    checkOutput($sformatf("job%0d_donePulseEnds", idx), {31'h0, done}, 32'h0);
    checkOutput($sformatf("job%0d_idleBusy", idx), {31'h0, busy}, 32'h0);
    checkOutput($sformatf("job%0d_wordsDoneHeld", idx), {16'h0, wordsDone}, {16'h0, v.expWords});
    if (v.count == 0)
      checkOutput($sformatf("job%0d_noValids", idx), validCycles, 0);
    checkOutput($sformatf("job%0d_readCount", idx), rdLog.size(), {16'h0, v.count});
    checkOutput($sformatf("job%0d_writeAddrCount", idx), awLog.size(), {16'h0, v.count});
    checkOutput($sformatf("job%0d_writeDataCount", idx), wLog.size(), {16'h0, v.count});
    for (int i = 0; i < int'(v.count); i++) begin
      if (i < rdLog.size())
        checkOutput($sformatf("job%0d_rdAddr%0d", idx, i), rdLog[i], v.src + 32'(4 * i));
      if (i < awLog.size())
        checkOutput($sformatf("job%0d_wrAddr%0d", idx, i), awLog[i], v.dst + 32'(4 * i));
      if (i < wLog.size())
        checkOutput($sformatf("job%0d_wrData%0d", idx, i), wLog[i], memData(v.src + 32'(4 * i)));
    end
  endtask

  // Reset values, directed job table, then asynchronous reset in the middle of a job
  initial begin : main
    jobVec_t jobs[6];
    jobVec_t freshJob;
    bit reachedWr;

    jobs[0] = '{32'h20000000, 32'h20000100, 16'd4, 0, 0, 1'b0, 13, 16'd4};
    jobs[1] = '{32'h00001000, 32'h00002000, 16'd0, 0, 0, 1'b0,  1, 16'd0};
    jobs[2] = '{32'h30000000, 32'h30000800, 16'd2, 1, 3, 1'b0, 13, 16'd2};
    jobs[3] = '{32'hFFFFFFF8, 32'h40000000, 16'd3, 0, 0, 1'b0, 10, 16'd3};
    jobs[4] = '{32'h50000000, 32'h50001000, 16'd3, 0, 0, 1'b1, 10, 16'd3};
    jobs[5] = '{32'h10000010, 32'hFFFFFFFC, 16'd2, 2, 0, 1'b0, 11, 16'd2};
    freshJob = '{32'h71000000, 32'h71000100, 16'd2, 0, 0, 1'b0, 7, 16'd2};

    resetActiveLow       = 1'b0;
    start                = 1'b0;
    srcAddress           = 32'h0;
    dstAddress           = 32'h0;
    wordCount            = 16'h0;
    dmaAxiReadReady      = 1'b0;
    dmaAxiReadData       = 32'h0;
    dmaAxiReadValidData  = 1'b0;
    dmaAxiWriteReady     = 1'b0;
    dmaAxiWriteReadyData = 1'b0;

    #13;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_wordsDone", {16'h0, wordsDone}, 32'h0);
    checkOutput("rst_valids", {28'h0, dmaAxiReadValid, dmaAxiReadReadyData, dmaAxiWriteValid, dmaAxiWriteValidData}, 32'h0);
    checkOutput("rst_rdAddr", dmaAxiReadAddress, 32'h0);
    checkOutput("rst_wrAddr", dmaAxiWriteAddress, 32'h0);
    checkOutput("rst_wrData", dmaAxiWriteData, 32'h0);
    @(negedge clock);
    resetActiveLow = 1'b1;
    repeat (2) @(posedge clock);

    for (int j = 0; j < 6; j++) begin
      applyStimulus(jobs[j], j);
    end

    $display("[TB] reset during a 4-word job");
    awDelay = 0;
    wDelay  = 0;
    @(negedge clock);
    srcAddress = 32'h70000000;
    dstAddress = 32'h70000100;
    wordCount  = 16'd4;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    srcAddress = 32'h0;
    dstAddress = 32'h0;
    wordCount  = 16'd0;
    reachedWr = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (dmaAxiWriteValid && wordsDone == 16'd1) begin
        reachedWr = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    checkOutput("midReset_reachedWr", {31'h0, reachedWr}, 32'h1);
    #2;
    resetActiveLow = 1'b0;
    #1;
    checkOutput("midReset_busy", {31'h0, busy}, 32'h0);
    checkOutput("midReset_done", {31'h0, done}, 32'h0);
    checkOutput("midReset_wordsDone", {16'h0, wordsDone}, 32'h0);
    checkOutput("midReset_valids", {28'h0, dmaAxiReadValid, dmaAxiReadReadyData, dmaAxiWriteValid, dmaAxiWriteValidData}, 32'h0);
    checkOutput("midReset_rdAddr", dmaAxiReadAddress, 32'h0);
    checkOutput("midReset_wrAddr", dmaAxiWriteAddress, 32'h0);
    checkOutput("midReset_wrData", dmaAxiWriteData, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("midReset_noDonePulse", {31'h0, done}, 32'h0);
    @(negedge clock);
    resetActiveLow = 1'b1;
    applyStimulus(freshJob, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Single-channel memory-to-memory copy engine that acts as the DMA master on the system bus interconnect. It drives the interconnect's DMA read and write channels directly. Software starts it with a source address, destination address and word count. It then copies one 32-bit word at a time: read a word, write that word, advance both addresses by 4, and repeat. When the last word is written it raises busy low and pulses done.

## Interface
Parameters:
- COUNT_WIDTH, 16: width of the word-count and progress counters.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetActiveLow  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- srcAddress  in  32  first source byte address; must be word aligned.
- dstAddress  in  32  first destination byte address; must be word aligned.
- wordCount  in  COUNT_WIDTH  number of 32-bit words to copy.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle completion pulse.
- wordsDone  out  COUNT_WIDTH  count of words fully written in the current or last job.
- dmaAxiReadAddress  out  32  read address.
- dmaAxiReadValid  out  1  read address valid.
- dmaAxiReadReady  in  1  read address accepted.
- dmaAxiReadData  in  32  read data.
- dmaAxiReadValidData  in  1  read data valid.
- dmaAxiReadReadyData  out  1  engine ready for read data.
- dmaAxiWriteAddress  out  32  write address.
- dmaAxiWriteValid  out  1  write address valid.
- dmaAxiWriteReady  in  1  write address accepted.
- dmaAxiWriteData  out  32  write data.
- dmaAxiWriteValidData  out  1  write data valid.
- dmaAxiWriteReadyData  in  1  write data accepted.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE.
- A transfer on any channel completes in a cycle where its valid and its ready are both high at the rising edge.
- IDLE:
  - start=1 with wordCount≠0 latches srcAddress into rdPtr, dstAddress into wrPtr and wordCount into remaining; clears wordsDone; goes to RD_ADDR.
  - start=1 with wordCount=0 goes straight to DONE; no bus traffic; wordsDone cleared to 0.
- RD_ADDR:
  - dmaAxiReadValid=1 and dmaAxiReadAddress=rdPtr.
  - Holds until dmaAxiReadReady=1, then goes to RD_DATA.
- RD_DATA:
  - dmaAxiReadReadyData=1.
  - When dmaAxiReadValidData=1, captures dmaAxiReadData into dataReg, sets rdPtr+=4, goes to WR.
- WR:
  - On entry, dmaAxiWriteValid and dmaAxiWriteValidData both go high.
  - dmaAxiWriteAddress=wrPtr and dmaAxiWriteData=dataReg, both stable throughout WR.
  - Each valid drops independently in the cycle after its own ready is sampled. Two sticky flags, addrSent and dataSent, record this.
  - When both channels have completed (either in the same cycle or in different cycles): wrPtr+=4, remaining-=1, wordsDone+=1.
  - If the remaining count before that decrement was 1, go to DONE; otherwise go to RD_ADDR.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE; no queuing.
- Addresses wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000). No error is flagged.
- Low address bits are passed through unchanged. Unaligned addresses are the software's responsibility.
- Only one outstanding transaction at a time; read and write never overlap.
- Outputs are registered or decoded from state. No combinational path from any input to any output.
- wordsDone holds its final value in IDLE until the next accepted start.

## Timing
- Reset values:
  - busy=0, done=0, wordsDone=0.
  - All valid outputs and dmaAxiReadReadyData =0.
  - All address and data outputs =0.
  - State = IDLE.
- Reset asserted mid-job: immediately returns to IDLE and drops all valids. No completion pulse.
- Start at edge N → state RD_ADDR and busy=1 during cycle N+1.
- With zero-wait slaves, each word takes 3 cycles (RD_ADDR, RD_DATA, WR). A job of n words takes 3n+1 cycles from start to done.
- Zero-length job: done=1 in cycle N+1; busy stays 0.
- Valids never drop before their ready is sampled; address and data never change while their valid is high.
- The interconnect may hold ready low indefinitely; the engine waits with no timeout.

## Test plan
- src=0x20000000, dst=0x20000100, count=4, zero-wait RAM preloaded with 0xA0..0xA3 → writes 0xA0..0xA3 to 0x20000100..0x2000010C; done at cycle 13 after start; wordsDone=4.
- count=0 → no valid ever asserted; done pulses in cycle N+1; busy stays 0; wordsDone=0.
- Write handshake split: dmaAxiWriteReady returns at +1 cycle and dmaAxiWriteReadyData at +3 cycles → exactly one write per word; wrPtr advances once per word; addresses and data stay stable while stalled.
- Address wrap: src=0xFFFFFFF8, count=3 → read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- start pulsed mid-job with new arguments → ignored; the original job completes unchanged.
- resetActiveLow dropped while in WR after 1 of 4 words → all outputs return to reset values asynchronously. A fresh start then copies from the new arguments.
